// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller and body datapath.
package snake_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLACE,
        PLAY,
        GROW,
        OVER
    } game_state_t;

    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    localparam int          CELLS_PER_AXIS = 61;

    localparam int DEF_X_MIN   = 200;
    localparam int DEF_X_MAX   = 500;
    localparam int DEF_Y_MIN   = 200;
    localparam int DEF_Y_MAX   = 500;
    localparam int DEF_GRID    = 5;
    localparam int DEF_MAX_LEN = 30;

    localparam logic [9:0] FOOD_RESET = 10'd350;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/snake_game_if.sv
// Signals between the game controller (master) and the body/display side (slave).
interface snake_game_if;
    logic       start;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic [6:0] snake_length;
    logic       self_hit;
    logic       move_en;
    logic       grow;
    logic       snake_clr;
    logic [9:0] food_x;
    logic [9:0] food_y;
    logic [9:0] score;
    logic       game_over;
    logic       win;
    logic       playing;

    modport master (
        input  start, head_x, head_y, snake_length, self_hit,
        output move_en, grow, snake_clr, food_x, food_y, score, game_over, win, playing
    );

    modport slave (
        output start, head_x, head_y, snake_length, self_hit,
        input  move_en, grow, snake_clr, food_x, food_y, score, game_over, win, playing
    );
endinterface

// File: rtl/snake_food_lfsr.sv
// Free-running food LFSR and candidate cell check (on-grid range, not under the head).
module snake_food_lfsr
    import snake_pkg::*;
#(
    parameter int X_MIN = DEF_X_MIN,
    parameter int Y_MIN = DEF_Y_MIN,
    parameter int GRID  = DEF_GRID
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] head_x,
    input  logic [9:0] head_y,
    output logic       cand_valid,
    output logic [9:0] cand_x,
    output logic [9:0] cand_y
);
    logic [15:0] lfsr;
    logic [5:0]  ix;
    logic [5:0]  iy;

    always_ff @(posedge clk) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= lfsr_next(lfsr);
    end

    assign ix     = lfsr[5:0];
    assign iy     = lfsr[11:6];
    assign cand_x = 10'(X_MIN) + 10'(GRID) * {4'd0, ix};
    assign cand_y = 10'(Y_MIN) + 10'(GRID) * {4'd0, iy};

    assign cand_valid = (ix < 6'(CELLS_PER_AXIS)) && (iy < 6'(CELLS_PER_AXIS)) &&
                        !((cand_x == head_x) && (cand_y == head_y));
endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move rate, food placement, grow requests, collisions, score.
// state | meaning
// IDLE  | after reset, waiting for a start edge
// PLACE | sampling LFSR until a legal food cell appears
// PLAY  | stepping the body, watching for collision or food
// GROW  | waiting for the datapath to report a length change
// OVER  | game ended (win flags a MAX_LEN ending), waiting for start
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV     = 1_000_000,
    parameter int X_MIN        = DEF_X_MIN,
    parameter int X_MAX        = DEF_X_MAX,
    parameter int Y_MIN        = DEF_Y_MIN,
    parameter int Y_MAX        = DEF_Y_MAX,
    parameter int GRID         = DEF_GRID,
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int GROW_TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    snake_game_if.master game
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int WAIT_W = $clog2(GROW_TIMEOUT + 1);

    game_state_t       state;
    logic              start_prev;
    logic [TICK_W-1:0] tick_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [6:0]        len_q;
    logic              move_en_q, grow_q, snake_clr_q;
    logic [9:0]        food_x_q, food_y_q, score_q;
    logic              game_over_q, win_q, playing_q;

    logic       cand_valid;
    logic [9:0] cand_x, cand_y;
    logic       start_rise, out_of_bounds, at_food;

    snake_food_lfsr #(.X_MIN(X_MIN), .Y_MIN(Y_MIN), .GRID(GRID)) u_food (
        .clk        (clk),
        .rst        (rst),
        .head_x     (game.head_x),
        .head_y     (game.head_y),
        .cand_valid (cand_valid),
        .cand_x     (cand_x),
        .cand_y     (cand_y)
    );

    assign start_rise    = game.start & ~start_prev;
    assign out_of_bounds = (game.head_x < 10'(X_MIN)) || (game.head_x > 10'(X_MAX)) ||
                           (game.head_y < 10'(Y_MIN)) || (game.head_y > 10'(Y_MAX));
    assign at_food       = (game.head_x == food_x_q) && (game.head_y == food_y_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            start_prev  <= 1'b1;
            tick_cnt    <= '0;
            wait_cnt    <= '0;
            len_q       <= '0;
            move_en_q   <= 1'b0;
            grow_q      <= 1'b0;
            snake_clr_q <= 1'b0;
            food_x_q    <= FOOD_RESET;
            food_y_q    <= FOOD_RESET;
            score_q     <= '0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            start_prev  <= game.start;
            move_en_q   <= 1'b0;
            grow_q      <= 1'b0;
            snake_clr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        snake_clr_q <= 1'b1;
                        score_q     <= '0;
                        state       <= PLACE;
                    end
                end
                PLACE: begin
                    if (cand_valid) begin
                        food_x_q  <= cand_x;
                        food_y_q  <= cand_y;
                        tick_cnt  <= TICK_W'(TICK_DIV - 1);
                        playing_q <= 1'b1;
                        state     <= PLAY;
                    end
                end
                PLAY: begin
                    // Collision outranks eating; the step strobe only fires when staying in PLAY.
                    if (out_of_bounds || game.self_hit) begin
                        game_over_q <= 1'b1;
                        playing_q   <= 1'b0;
                        state       <= OVER;
                    end else if (at_food) begin
                        grow_q   <= 1'b1;
                        if (score_q != 10'h3FF) score_q <= score_q + 10'd1;
                        len_q    <= game.snake_length;
                        wait_cnt <= WAIT_W'(GROW_TIMEOUT - 1);
                        state    <= GROW;
                    end else if (tick_cnt == '0) begin
                        move_en_q <= 1'b1;
                        tick_cnt  <= TICK_W'(TICK_DIV - 1);
                    end else begin
                        tick_cnt <= tick_cnt - 1'b1;
                    end
                end
                GROW: begin
                    if (game.snake_length >= 7'(MAX_LEN)) begin
                        game_over_q <= 1'b1;
                        win_q       <= 1'b1;
                        playing_q   <= 1'b0;
                        state       <= OVER;
                    end else if ((game.snake_length != len_q) || (wait_cnt == '0)) begin
                        playing_q <= 1'b0;
                        state     <= PLACE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        snake_clr_q <= 1'b1;
                        score_q     <= '0;
                        win_q       <= 1'b0;
                        game_over_q <= 1'b0;
                        state       <= PLACE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign game.move_en   = move_en_q;
    assign game.grow      = grow_q;
    assign game.snake_clr = snake_clr_q;
    assign game.food_x    = food_x_q;
    assign game.food_y    = food_y_q;
    assign game.score     = score_q;
    assign game.game_over = game_over_q;
    assign game.win       = win_q;
    assign game.playing   = playing_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: PLAY-state vector table, food scoreboard and multi-cycle sequences.
module tb_snake_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    snake_game_if game_if ();

    snake_game_ctrl #(.TICK_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .game (game_if)
    );

    typedef struct {
        logic       use_food;
        logic [9:0] hx;
        logic [9:0] hy;
        logic       hit;
        logic       exp_over;
        logic       exp_grow;
    } vec_t;

    vec_t        vecs[12];
    int          checks = 0;
    int          errors = 0;
    int          exp_score = 0;
    int          exp_q[$];
    logic [15:0] m_lfsr = 16'hACE1;
    logic        grow_seen = 1'b0;

    localparam logic [9:0] NEUTRAL = 10'd201;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; also scoreboards food placement against a reference LFSR and grow against queued scores.
    task automatic tick();
        logic [9:0] cx, cy, pfx, pfy;
        logic       cv, r;
        cx  = 10'd200 + 10'd5 * {4'd0, m_lfsr[5:0]};
        cy  = 10'd200 + 10'd5 * {4'd0, m_lfsr[11:6]};
        cv  = (m_lfsr[5:0] <= 6'd60) && (m_lfsr[11:6] <= 6'd60) &&
              !((cx == game_if.head_x) && (cy == game_if.head_y));
        r   = rst;
        pfx = game_if.food_x;
        pfy = game_if.food_y;
        @(posedge clk);
        #1;
        m_lfsr = r ? {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]} : 16'hACE1;
        if (r && ((game_if.food_x != pfx) || (game_if.food_y != pfy))) begin
            check("food_cell", {game_if.food_x, game_if.food_y}, {cx, cy});
            check("food_legal", cv, 1'b1);
        end
        grow_seen = game_if.grow;
        if (game_if.grow) begin
            if (exp_q.size() == 0) check("grow_unexpected", 1, 0);
            else check("grow_score", game_if.score, exp_q.pop_front());
        end
    endtask

    task automatic neutral();
        game_if.head_x   = NEUTRAL;
        game_if.head_y   = NEUTRAL;
        game_if.self_hit = 1'b0;
    endtask

    task automatic do_start();
        game_if.start = 1'b1;
        tick();
        check("clr_pulse", game_if.snake_clr, 1'b1);
        check("clr_score", game_if.score, 0);
        game_if.start = 1'b0;
        tick();
        check("clr_width", game_if.snake_clr, 1'b0);
        exp_score = 0;
    endtask

    task automatic wait_play();
        int n = 0;
        while (!game_if.playing && n < 300) begin
            tick();
            n++;
        end
        if (!game_if.playing) check("play_timeout", 0, 1);
    endtask

    task automatic eat();
        game_if.head_x = game_if.food_x;
        game_if.head_y = game_if.food_y;
        exp_score++;
        exp_q.push_back(exp_score);
        tick();
        check("eat_grow", grow_seen, 1'b1);
        neutral();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;

        vecs[0]  = '{1'b0, 10'd201, 10'd201, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 10'd500, 10'd201, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 10'd201, 10'd500, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 10'd199, 10'd300, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 10'd501, 10'd201, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 10'd201, 10'd199, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 10'd201, 10'd501, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 10'd505, 10'd300, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 10'd0,   10'd0,   1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 10'd201, 10'd201, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 10'd0,   10'd0,   1'b0, 1'b0, 1'b1};

        // Reset held with start high; start must not fire on release.
        rst = 1'b0;
        game_if.start        = 1'b1;
        game_if.snake_length = 7'd1;
        neutral();
        repeat (3) tick();
        check("rst_move_en", game_if.move_en, 1'b0);
        check("rst_grow", game_if.grow, 1'b0);
        check("rst_clr", game_if.snake_clr, 1'b0);
        check("rst_food", {game_if.food_x, game_if.food_y}, {10'd350, 10'd350});
        check("rst_score", game_if.score, 0);
        check("rst_flags", {game_if.game_over, game_if.win, game_if.playing}, 3'b000);
        rst = 1'b1;
        bad = 0;
        repeat (5) begin
            tick();
            if (game_if.snake_clr || game_if.playing || game_if.food_x != 10'd350) bad++;
        end
        check("held_start_ignored", bad, 0);
        game_if.start = 1'b0;
        tick();
        do_start();
        wait_play();

        // Step rate with TICK_DIV=4.
        n = 0;
        do begin tick(); n++; end while (!game_if.move_en && n < 20);
        check("first_move", n, 4);
        n = 0;
        do begin tick(); n++; end while (!game_if.move_en && n < 20);
        check("move_period", n, 4);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].use_food) begin
                game_if.head_x = game_if.food_x;
                game_if.head_y = game_if.food_y;
            end else begin
                game_if.head_x = vecs[i].hx;
                game_if.head_y = vecs[i].hy;
            end
            game_if.self_hit = vecs[i].hit;
            if (vecs[i].exp_grow) begin
                exp_score++;
                exp_q.push_back(exp_score);
            end
            tick();
            check($sformatf("vec%0d_over", i), game_if.game_over, vecs[i].exp_over);
            check($sformatf("vec%0d_grow", i), grow_seen, vecs[i].exp_grow);
            check($sformatf("vec%0d_score", i), game_if.score, exp_score);
            neutral();
            if (vecs[i].exp_over) begin
                do_start();
                wait_play();
            end else if (vecs[i].exp_grow) begin
                repeat (3) tick();
                game_if.snake_length = game_if.snake_length + 7'd1;
                tick();
                check("grow_exit_on_len", game_if.playing, 1'b0);
                wait_play();
            end
        end

        // GROW with frozen length leaves after the timeout.
        eat();
        n = 0;
        do begin tick(); n++; end while (game_if.playing && n < 400);
        check("grow_timeout", n, 255);
        wait_play();

        // Reset in the middle of GROW.
        eat();
        tick();
        rst = 1'b0;
        tick();
        check("midrst_flags", {game_if.game_over, game_if.win, game_if.playing, game_if.grow}, 4'b0000);
        check("midrst_food", {game_if.food_x, game_if.food_y}, {10'd350, 10'd350});
        check("midrst_score", game_if.score, 0);
        rst = 1'b1;
        exp_score = 0;
        repeat (2) tick();
        check("midrst_idle", game_if.playing, 1'b0);
        do_start();
        wait_play();

        // Win by length, then restart.
        eat();
        game_if.snake_length = 7'd30;
        tick();
        check("win_flags", {game_if.game_over, game_if.win, game_if.playing}, 3'b110);
        game_if.snake_length = 7'd1;
        game_if.start = 1'b1;
        tick();
        check("restart_clr", game_if.snake_clr, 1'b1);
        check("restart_score", game_if.score, 0);
        check("restart_flags", {game_if.game_over, game_if.win, game_if.playing}, 3'b000);
        game_if.start = 1'b0;
        exp_score = 0;
        tick();
        wait_play();

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game sequencer for the snake datapath. It owns the move rate, food placement, grow requests, wall/self-collision detection, score and game-over/win status. It sits between the button/start inputs and the snake body datapath: it pulses `move_en` to step the body, pulses `grow` when the head reaches the food, and pulses `snake_clr` to restart the body. The display path reads `food_x`/`food_y`, `score` and the status flags.

## Interface
- `TICK_DIV`, 1_000_000: clk cycles per snake step (≥2).
- `X_MIN`/`X_MAX`, 200/500: legal head x range, inclusive.
- `Y_MIN`/`Y_MAX`, 200/500: legal head y range, inclusive.
- `GRID`, 5: pixel pitch of one cell.
- `MAX_LEN`, 30: body length that wins the game.
- `GROW_TIMEOUT`, 255: cycles to wait for a length change after `grow`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: level input, rising-edge detected internally.
- `head_x` in 10: current head x from the body datapath.
- `head_y` in 10: current head y from the body datapath.
- `snake_length` in 7: current body length.
- `self_hit` in 1: head overlaps a body segment (from the datapath).
- `move_en` out 1: one-cycle step strobe.
- `grow` out 1: one-cycle grow request.
- `snake_clr` out 1: one-cycle body restart.
- `food_x` out 10: food cell x, always on the grid.
- `food_y` out 10: food cell y, always on the grid.
- `score` out 10: foods eaten. Saturates at 1023.
- `game_over` out 1: level, high in OVER.
- `win` out 1: level, high in OVER when ended by `MAX_LEN`.
- `playing` out 1: level, high in PLAY or GROW.

## Operation
- States are IDLE, PLACE, PLAY, GROW and OVER.
- **IDLE**: wait for a `start` rising edge. On the edge, pulse `snake_clr`, clear `score`, and go to PLACE.
- **PLACE**: each cycle, form `ix = lfsr[5:0]` and `iy = lfsr[11:6]`.
  - Accept the sample when `ix ≤ 60`, `iy ≤ 60`, and the cell ≠ (`head_x`,`head_y`).
  - On accept: `food_x = X_MIN + GRID*ix`, `food_y = Y_MIN + GRID*iy`, go to PLAY.
  - On reject: stay in PLACE and resample next cycle.
- **PLAY**: the tick counter runs from 0 to `TICK_DIV-1`. `move_en` is high for the one cycle where count = `TICK_DIV-1`; the counter then wraps to 0. Each cycle, priority order:
  1. If the head is outside [X_MIN,X_MAX]×[Y_MIN,Y_MAX], or `self_hit`=1 → OVER.
  2. Else if head = food → pulse `grow`, increment `score` (saturating), latch `snake_length` → GROW.
- **GROW**: `move_en` stays low and the counter holds.
  - `snake_length` ≥ `MAX_LEN` → OVER with `win`=1.
  - Else `snake_length` ≠ latched value, or the wait counter reaches `GROW_TIMEOUT` → PLACE.
- **OVER**: `game_over`=1. A `start` rising edge pulses `snake_clr`, clears `score`, `win` and `game_over`, and goes to PLACE.
- The LFSR is 16-bit Fibonacci with taps 16,14,13,11 and seed 16'hACE1. It advances every non-reset cycle in every state.

## Timing
- **Reset** (`rst`=0 at an edge) applies on that edge from any state, including mid-GROW or mid-PLACE:
  - state = IDLE, tick and wait counters = 0, lfsr = seed.
  - `move_en` = `grow` = `snake_clr` = 0.
  - `food_x` = `food_y` = 350, `score` = 0.
  - `game_over` = `win` = `playing` = 0.
  - The start edge detector's previous-value register = 1, so a `start` held through reset does not fire.
- All outputs are registered.
- `snake_clr`, `grow` and `move_en` are exactly one cycle wide. At most one of them is high in any cycle.
- Start edge to `snake_clr` high: 1 cycle.
- PLACE lasts at least 1 cycle. There is no upper bound other than LFSR statistics.
- Head = food to `grow` high: 1 cycle, with the state change on the same edge.
- First `move_en` occurs `TICK_DIV` cycles after entering PLAY from PLACE, because the counter clears on PLACE exit.
- When collision and food match occur in the same cycle, collision wins: no `grow`, no score change.
- `start` edges in PLACE, PLAY or GROW are ignored.

## Structure
- Shared package `snake_pkg` holds:
  - the state enum `game_state_t` (IDLE, PLACE, PLAY, GROW, OVER);
  - the `LFSR_SEED` constant;
  - the `CELLS_PER_AXIS` = 61 constant;
  - the default bound, GRID and MAX_LEN constants, shared with the body datapath.
- Sub-module `snake_food_lfsr` contains the 16-bit LFSR plus the accept logic (range and head check). It outputs `cand_valid`, `cand_x` and `cand_y`.
- The FSM, tick counter, GROW wait counter and score stay in the top module.

## Test plan
- **Reset/idle**: hold `rst`=0 for 3 cycles, then release with `start`=1 held → all outputs at reset values, no `snake_clr` and no PLACE entry until `start` falls and rises again.
- **Tick rate**: with `TICK_DIV`=4, start the game with the head off-food → `move_en` high every 4th cycle, first pulse 4 cycles after PLAY entry.
- **Eat**: force food = (300,300), drive head = (300,300) → `grow` pulses once and `score` 0→1. Step `snake_length` 1→2 three cycles later → PLACE, new food on grid and ≠ (300,300).
- **Collision priority**: head = food = (200,200) with `self_hit`=1 in the same cycle → `game_over`=1, `score` unchanged, no `grow`.
- **Wall and timeout**: head_x = 505 → OVER next cycle. Separately, in GROW with `snake_length` frozen → PLACE after exactly 255 wait cycles.
- **Win and restart**: `snake_length` reaches 30 in GROW → `win`=1 and `game_over`=1. A `start` edge → `snake_clr` pulse, `score`=0, `win`=0, state PLACE.
